// File: rtl/series_sched.sv
// series_sched: round-robin scheduler sharing one Maclaurin series engine among NREQ requesters.
// Optional engine watchdog enabled by defining SERIES_SCHED_TIMEOUT_EN (limit TOUT cycles).
module series_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int TOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    fsel,
    input  logic [DW*NREQ-1:0]   xin,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        res,
    output logic                 err,
    output logic                 busy,
    output logic                 eng_start,
    output logic [1:0]           eng_fsel,
    output logic [DW-1:0]        eng_x,
    input  logic                 eng_done,
    input  logic [DW-1:0]        eng_res
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TOUT < 2) begin : g_bad_cfg
        $error("series_sched: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAITLO, WAITHI, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, idx_q, win_idx, cand;
    logic          win_vld, grant, waiting, tout_fire;
    logic [1:0]    fsel_q;
    logic [DW-1:0] x_q, res_q;
    logic          err_q;

    // Rotating priority search starting just after the last served requester.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_q) + 1 + i) % NREQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign grant   = (state_q == IDLE) && win_vld && eng_done;
    assign waiting = (state_q == WAITLO) || (state_q == WAITHI);

`ifdef SERIES_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TOUT + 1);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q == ISSUE) begin
            cnt_q <= '0;
        end else if (waiting) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires in the last wait cycle so that ack lands exactly TOUT cycles after ISSUE.
    assign tout_fire = waiting && (cnt_q == CW'(TOUT - 2)) && !(state_q == WAITHI && eng_done);
`else
    assign tout_fire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = GRANT;
            GRANT:   state_d = (fsel_q == 2'd3) ? RESP : ISSUE;
            ISSUE:   state_d = WAITLO;
            WAITLO: begin
                if (tout_fire)     state_d = RESP;
                else if (!eng_done) state_d = WAITHI;
            end
            WAITHI:  if (eng_done || tout_fire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(NREQ - 1);
            err_q    <= 1'b0;
            eng_fsel <= '0;
            eng_x    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == GRANT) begin
                if (fsel_q == 2'd3) begin
                    err_q <= 1'b1;
                end else begin
                    eng_fsel <= fsel_q;
                    eng_x    <= x_q;
                end
            end
            if (tout_fire) err_q <= 1'b1;
            if (state_q == RESP) begin
                ptr_q <= idx_q;
                err_q <= 1'b0;
            end
        end
    end

    // Job data: latched on grant, result cleared in GRANT so error paths return zero.
    always_ff @(posedge clk) begin
        if (grant) begin
            idx_q  <= win_idx;
            fsel_q <= fsel[2*win_idx +: 2];
            x_q    <= xin[DW*win_idx +: DW];
        end
        if (state_q == GRANT) begin
            res_q <= '0;
        end else if (state_q == WAITHI && eng_done) begin
            res_q <= eng_res;
        end
    end

    assign busy      = (state_q != IDLE);
    assign eng_start = (state_q == ISSUE);
    assign ack       = (state_q == RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign res       = (state_q == RESP) ? res_q : '0;
    assign err       = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_series_sched.sv
// Scoreboard bench for series_sched with a behavioural engine model; covers the optional watchdog build too.
module tb_series_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  fsel;
    logic [63:0] xin;
    logic [3:0]  ack;
    logic [15:0] res;
    logic        err, busy, eng_start;
    logic [1:0]  eng_fsel;
    logic [15:0] eng_x;
    logic        eng_done;
    logic [15:0] eng_res;

    series_sched #(.NREQ(4), .DW(16), .TOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .fsel(fsel), .xin(xin),
        .ack(ack), .res(res), .err(err), .busy(busy),
        .eng_start(eng_start), .eng_fsel(eng_fsel), .eng_x(eng_x),
        .eng_done(eng_done), .eng_res(eng_res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ack;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;

    int          eng_lat   = 3;
    bit          eng_hold  = 1'b0;
    bit          use_fixed = 1'b0;
    logic [15:0] eng_val   = 16'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] r, input logic e);
        exp_t x;
        x.ack = a;
        x.res = r;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 4'b0 && n < limit);
        if (ack == 4'b0) chk("ack_wait", 32'd0, 32'd1);
    endtask

    // Engine: done drops the cycle after the start pulse, rises eng_lat cycles later unless held.
    initial begin
        logic [15:0] xcap;
        eng_done = 1'b1;
        eng_res  = 16'h0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                xcap = eng_x;
                @(negedge clk);
                eng_done = 1'b0;
                repeat (eng_lat) @(negedge clk);
                while (eng_hold) @(negedge clk);
                eng_done = 1'b1;
                eng_res  = use_fixed ? eng_val : ~xcap;
            end
        end
    end

    // Monitor: every ack must match the next queued expectation and last a single cycle.
    initial begin
        bit   ack_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) start_cnt++;
            if ((ack != 4'b0) === 1'b1) begin
                chk("ack_one_cycle", 32'(ack_prev), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("mon_ack", 32'(ack), 32'(e.ack));
                    chk("mon_res", 32'(res), 32'(e.res));
                    chk("mon_err", 32'(err), 32'(e.err));
                end
            end
            ack_prev = ((ack != 4'b0) === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, s0, lowcnt;
        rst  = 1'b1;
        req  = 4'b0;
        fsel = 8'h0;
        xin  = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(eng_start), 32'd0);
        chk("rst_efsel", 32'(eng_fsel), 32'd0);
        chk("rst_ex", 32'(eng_x), 32'd0);
        rst = 1'b0;

        // Single request from requester 1, fixed engine result, operand changed mid-job.
        @(negedge clk);
        eng_lat   = 20;
        use_fixed = 1'b1;
        eng_val   = 16'h0D2F;
        xin[31:16] = 16'h1000;
        fsel[3:2]  = 2'd0;
        push(4'b0010, 16'h0D2F, 1'b0);
        s0  = start_cnt;
        req = 4'b0010;
        @(negedge clk);
        chk("t1_grant_start", 32'(eng_start), 32'd0);
        chk("t1_grant_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_issue_start", 32'(eng_start), 32'd1);
        chk("t1_issue_ex", 32'(eng_x), 32'h1000);
        chk("t1_issue_efsel", 32'(eng_fsel), 32'd0);
        @(negedge clk);
        chk("t1_waitlo_start", 32'(eng_start), 32'd0);
        xin[31:16] = 16'hBEEF;
        fsel[3:2]  = 2'd2;
        repeat (7) @(negedge clk);
        chk("t1_stable_ex", 32'(eng_x), 32'h1000);
        chk("t1_stable_efsel", 32'(eng_fsel), 32'd0);
        // ack expected in cycle 24 after req: 2 overhead, WAITLO, 20 low cycles, done cycle, RESP.
        wait_ack(100, n);
        chk("t1_ack_latency", 32'(n), 32'd14);
        chk("t1_ack_direct", 32'(ack), 32'b0010);
        chk("t1_hold_ex", 32'(eng_x), 32'h1000);
        req = 4'b0;
        @(negedge clk);
        chk("t1_start_pulses", 32'(start_cnt - s0), 32'd1);

        // Reset so the pointer starts at NREQ-1, then strict rotation with all lines held.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        eng_lat   = 3;
        use_fixed = 1'b0;
        fsel      = 8'h0;
        xin       = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        push(4'b0001, 16'hFEFF, 1'b0);
        push(4'b0010, 16'hFDFF, 1'b0);
        push(4'b0100, 16'hFCFF, 1'b0);
        push(4'b1000, 16'hFBFF, 1'b0);
        push(4'b0001, 16'hFEFF, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(100, n);
            if (k == 4) req = 4'b0;
            @(negedge clk);
            chk("rr_gap_busy", 32'(busy), 32'd0);
            chk("rr_gap_ack", 32'(ack), 32'd0);
        end

        // Reserved function code: error response without touching the engine.
        fsel[5:4] = 2'd3;
        push(4'b0100, 16'h0000, 1'b1);
        s0  = start_cnt;
        req = 4'b0100;
        @(negedge clk);
        chk("rsv_grant_start", 32'(eng_start), 32'd0);
        @(negedge clk);
        chk("rsv_ack", 32'(ack), 32'b0100);
        chk("rsv_err", 32'(err), 32'd1);
        chk("rsv_res", 32'(res), 32'd0);
        req = 4'b0;
        @(negedge clk);
        chk("rsv_no_start", 32'(start_cnt - s0), 32'd0);

        // Reset while waiting on a held engine; no grant until the engine reports done.
        eng_lat    = 2;
        eng_hold   = 1'b1;
        fsel[7:6]  = 2'd1;
        xin[63:48] = 16'h1234;
        req = 4'b1000;
        repeat (5) @(negedge clk);
        chk("rsr_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rsr_ack", 32'(ack), 32'd0);
        chk("rsr_res", 32'(res), 32'd0);
        chk("rsr_err", 32'(err), 32'd0);
        chk("rsr_busy", 32'(busy), 32'd0);
        chk("rsr_start", 32'(eng_start), 32'd0);
        chk("rsr_efsel", 32'(eng_fsel), 32'd0);
        chk("rsr_ex", 32'(eng_x), 32'd0);
        lowcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) lowcnt++;
        end
        chk("rsr_no_grant", 32'(lowcnt), 32'd0);
        push(4'b1000, 16'hEDCB, 1'b0);
        eng_hold = 1'b0;
        wait_ack(100, n);
        req = 4'b0;
        repeat (3) @(negedge clk);

`ifdef SERIES_SCHED_TIMEOUT_EN
        // Engine never finishes: watchdog error response TOUT cycles after ISSUE.
        eng_lat   = 0;
        eng_hold  = 1'b1;
        fsel[3:2] = 2'd2;
        push(4'b0010, 16'h0000, 1'b1);
        req = 4'b0010;
        repeat (2) @(negedge clk);
        chk("to_issue", 32'(eng_start), 32'd1);
        wait_ack(200, n);
        chk("to_latency", 32'(n), 32'd64);
        req = 4'b0;
        eng_hold = 1'b0;
        repeat (5) @(negedge clk);
`else
        // Engine never finishes: without the watchdog the block stays busy.
        eng_lat   = 0;
        eng_hold  = 1'b1;
        fsel[3:2] = 2'd2;
        req = 4'b0010;
        lowcnt = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) lowcnt++;
        end
        chk("hang_busy", 32'(lowcnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0;
        eng_hold = 1'b0;
        repeat (5) @(negedge clk);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
